// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encodings,
// status bit positions and default register addresses.
package mmio_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_PAR     = 4;
    localparam int unsigned STAT_CNT_LSB = 8;

    localparam logic [31:0] DEF_TX_DATA_ADDR   = 32'h1001_0024;
    localparam logic [31:0] DEF_TX_STATUS_ADDR = 32'h1001_0028;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the EX/MEM store/load bus.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 16,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [31:0] TX_DATA_ADDR   = DEF_TX_DATA_ADDR,
    parameter logic [31:0] TX_STATUS_ADDR = DEF_TX_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Tx,
    output logic        TxBusy,
    output logic        Overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          ovf_q;

    logic          wr_data, wr_status, rd_status, baud_end, load, drop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full, fifo_empty;
    logic [AW:0]   fifo_count;
    logic [31:0]   status;
    logic          unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign wr_data   = MemWrite && (Address == TX_DATA_ADDR);
    assign wr_status = MemWrite && (Address == TX_STATUS_ADDR);
    assign rd_status = MemRead && (Address == TX_STATUS_ADDR);
    assign baud_end  = (baud_q == BW'(CLKS_PER_BIT - 1));

    // Head byte leaves the FIFO when a new frame starts, from IDLE or at the end of STOP.
    assign load = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_end));
    assign drop = wr_data && fifo_full && !load;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (load),
        .wdata (WriteData[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = (state_q == ST_IDLE || baud_end) ? '0 : baud_q + BW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        case (state_q)
            ST_IDLE: ;
            ST_START: if (baud_end) state_d = ST_DATA;
            ST_DATA: begin
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: if (baud_end) state_d = ST_STOP;
            ST_STOP: if (baud_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d  = ST_START;
            shift_d  = fifo_rdata;
            parity_d = ^fifo_rdata;
            baud_d   = '0;
            bit_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            // A drop on the same edge as a clear leaves the flag set.
            if (drop) ovf_q <= 1'b1;
            else if (wr_status && WriteData[0]) ovf_q <= 1'b0;
        end
    end

    always_comb begin
        case (state_q)
            ST_START:  Tx = 1'b0;
            ST_DATA:   Tx = shift_q[0];
            ST_PARITY: Tx = parity_q;
            default:   Tx = 1'b1;
        endcase
    end

    assign TxBusy   = (state_q != ST_IDLE);
    assign Overflow = ovf_q;

    always_comb begin
        status                            = '0;
        status[STAT_BUSY]                 = TxBusy;
        status[STAT_FULL]                 = fifo_full;
        status[STAT_EMPTY]                = fifo_empty;
        status[STAT_OVF]                  = ovf_q;
`ifdef UART_TX_PARITY_EN
        status[STAT_PAR]                  = 1'b1;
`else
        status[STAT_PAR]                  = 1'b0;
`endif
        status[STAT_CNT_LSB +: (AW + 1)]  = fifo_count;
    end

    assign ReadData = rd_status ? status : '0;

endmodule
